// File: rtl/uart_wbm_pkg.sv
// Shared definitions for the UART-side Wishbone command master:
// FSM encodings, parameter defaults and the timeout counter width.
package uart_wbm_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_TIMEOUT    = 15;
  localparam int TMO_CNT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Count value seen during the last BUS cycle that may still wait for ack.
  function automatic logic [TMO_CNT_W-1:0] tmo_last(input int timeout);
    return TMO_CNT_W'(timeout - 1);
  endfunction

endpackage

// File: rtl/uart_wbm_timeout.sv
// Bus-cycle watchdog: counts waiting cycles while enabled, flags the
// TIMEOUT-th waiting cycle so the master can abort on that edge.
module uart_wbm_timeout
  import uart_wbm_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == tmo_last(TIMEOUT));

endmodule

// File: rtl/uart_wb_master.sv
// Single-outstanding command master: turns a valid/ready request into one
// Wishbone classic cycle and returns data or a timeout error as a response.
module uart_wb_master
  import uart_wbm_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_dat,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [7:0]            rsp_dat,
  output logic                  rsp_err,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [7:0]            wb_dat_o,
  input  logic [7:0]            wb_dat_i,
  input  logic                  wb_ack_i
);

  state_t state, state_next;
  logic   in_bus;
  logic   tmo_expired;

  assign in_bus = (state == ST_BUS);

  uart_wbm_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (wb_rst_i),
    .clear   (!in_bus),
    .enable  (in_bus && !wb_ack_i),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (req_valid) state_next = ST_BUS;
      ST_BUS:  if (wb_ack_i || tmo_expired) state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // cyc and stb come from the same decode so they can never diverge.
  always_comb begin
    req_ready = (state == ST_IDLE);
    wb_cyc_o  = in_bus;
    wb_stb_o  = in_bus;
    rsp_valid = (state == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      rsp_dat  <= '0;
      rsp_err  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            wb_we_o  <= req_we;
            wb_adr_o <= req_addr;
            wb_dat_o <= req_dat;
          end
        end
        ST_BUS: begin
          // A late ack on the final allowed cycle still counts as success.
          if (wb_ack_i) begin
            rsp_dat <= wb_we_o ? 8'h00 : wb_dat_i;
            rsp_err <= 1'b0;
          end else if (tmo_expired) begin
            rsp_dat <= 8'h00;
            rsp_err <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_dat <= 8'h00;
            rsp_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// Bench for uart_wb_master: vector table driven against a behavioural
// Wishbone slave, with a response scoreboard and hand-written reset cases.
module tb_uart_wb_master;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [2:0] req_addr;
  logic [7:0] req_dat;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_dat;
  logic       rsp_err;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_ack_i;

  uart_wb_master #(
    .ADDR_WIDTH (3),
    .TIMEOUT    (15)
  ) dut (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_dat   (req_dat),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];

  // Slave: acks when stb has been high for lat+1 sampled cycles; optional
  // trailing ack one cycle later, as a registered-ack slave would produce.
  int         s_lat   = 255;
  logic [7:0] s_rd    = 8'h00;
  logic       s_trail = 1'b0;
  int         s_cnt   = 0;
  logic       s_acked = 1'b0;

  always @(negedge clk) begin
    if (wb_stb_o) s_cnt = s_cnt + 1;
    else          s_cnt = 0;
    if (wb_stb_o && s_cnt == s_lat + 1) begin
      wb_ack_i = 1'b1;
      wb_dat_i = s_rd;
      s_acked  = 1'b1;
    end else if (s_trail && s_acked) begin
      wb_ack_i = 1'b1;
      wb_dat_i = 8'hC3;
      s_acked  = 1'b0;
    end else begin
      wb_ack_i = 1'b0;
      wb_dat_i = 8'hEE;
      s_acked  = 1'b0;
    end
  end

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] dat;
    int         lat;
    logic [7:0] rd;
    logic       trail;
    int         hold;
    logic [7:0] exp_dat;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int         cyc;
    int         stb_cyc;
    logic       bus_bad;
    logic       hold_bad;
    logic [7:0] d0;
    logic       e0;
    logic [8:0] exp;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    s_lat     = v.lat;
    s_rd      = v.rd;
    s_trail   = v.trail;
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_dat   = v.dat;
    rsp_ready = 1'b0;
    exp_q.push_back({v.exp_err, v.exp_dat});
    stb_cyc = 0;
    bus_bad = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    req_dat   = 8'h00;
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 60) begin
      if (wb_stb_o) begin
        stb_cyc++;
        if (wb_cyc_o !== 1'b1 || wb_we_o !== v.we || wb_adr_o !== v.addr ||
            (v.we && wb_dat_o !== v.dat)) bus_bad = 1'b1;
      end
      if (req_ready !== 1'b0 || wb_cyc_o !== wb_stb_o) bus_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("rsp_latency", cyc, v.exp_lat);
    check("stb_cycles", stb_cyc, v.exp_lat - 1);
    check("bus_signals", bus_bad, 0);
    d0 = rsp_dat;
    e0 = rsp_err;
    hold_bad = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_dat !== d0 || rsp_err !== e0 ||
          req_ready !== 1'b0 || wb_stb_o !== 1'b0) hold_bad = 1'b1;
    end
    if (v.hold > 0) check("rsp_hold", hold_bad, 0);
    rsp_ready = 1'b1;
    exp = exp_q.pop_front();
    check("rsp_dat", rsp_dat, exp[7:0]);
    check("rsp_err", rsp_err, exp[8]);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done", {rsp_valid, req_ready, wb_stb_o}, 3'b010);
    @(negedge clk);
    check("no_second_rsp", {rsp_valid, req_ready, wb_stb_o}, 3'b010);
    s_lat   = 255;
    s_trail = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            we    addr  dat    lat  rd     trail hold exp_dat exp_err exp_lat
    vecs[0] = '{1'b1, 3'd3, 8'h83,   1, 8'h77, 1'b0,  0, 8'h00, 1'b0,  3};
    vecs[1] = '{1'b0, 3'd5, 8'h00,   1, 8'h60, 1'b1,  0, 8'h60, 1'b0,  3};
    vecs[2] = '{1'b0, 3'd2, 8'h00, 255, 8'h11, 1'b0,  0, 8'h00, 1'b1, 16};
    vecs[3] = '{1'b0, 3'd7, 8'h00,  14, 8'hA5, 1'b0,  0, 8'hA5, 1'b0, 16};
    vecs[4] = '{1'b1, 3'd1, 8'h5A,   3, 8'h99, 1'b0, 10, 8'h00, 1'b0,  5};
    vecs[5] = '{1'b0, 3'd0, 8'h00,   0, 8'hFF, 1'b0,  0, 8'hFF, 1'b0,  2};
    vecs[6] = '{1'b0, 3'd4, 8'h00,  13, 8'h3C, 1'b1,  3, 8'h3C, 1'b0, 15};
    vecs[7] = '{1'b1, 3'd6, 8'hC0, 255, 8'h42, 1'b0,  4, 8'h00, 1'b1, 16};
    vecs[8] = '{1'b0, 3'd1, 8'h00,   2, 8'h81, 1'b0,  0, 8'h81, 1'b0,  4};

    wb_rst_i  = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_dat   = '0;
    rsp_ready = 1'b0;
    wb_ack_i  = 1'b0;
    wb_dat_i  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_dat}, 0);
    wb_rst_i = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset while a request is offered: reset must win, no cycle starts.
    @(negedge clk);
    wb_rst_i  = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 3'd2;
    @(negedge clk);
    check("rst_dominates", {req_ready, wb_stb_o, wb_cyc_o}, 3'b100);
    wb_rst_i  = 1'b0;
    req_valid = 1'b0;

    // Reset in the middle of a bus cycle that would otherwise time out.
    @(negedge clk);
    s_lat     = 255;
    req_valid = 1'b1;
    req_addr  = 3'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midbus_stb", {wb_cyc_o, wb_stb_o}, 2'b11);
    wb_rst_i = 1'b1;
    @(negedge clk);
    wb_rst_i = 1'b0;
    check("midbus_rst", {wb_cyc_o, wb_stb_o, rsp_valid, req_ready}, 4'b0001);
    repeat (20) @(negedge clk);
    check("midbus_no_rsp", {rsp_valid, req_ready}, 2'b01);
    run_vec(vecs[1]);

    // Reset while a response is being held off by the consumer.
    @(negedge clk);
    s_lat     = 1;
    s_rd      = 8'h5C;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 3'd4;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midresp_rsp", {rsp_valid, rsp_dat}, {1'b1, 8'h5C});
    wb_rst_i = 1'b1;
    @(negedge clk);
    wb_rst_i = 1'b0;
    check("midresp_rst", {rsp_valid, rsp_err, rsp_dat, req_ready}, 11'h001);
    s_lat = 255;

    run_vec(vecs[0]);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_wb_master.md
UART_WB_MASTER -- requirements
Module: uart_wb_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, Wishbone address width in bits (UART register space).
REQ-002 Parameter TIMEOUT, default 15, maximum BUS-state cycles to wait for wb_ack_i before aborting (range 1..255).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  command request present.
REQ-006 req_ready  output  1  block can accept a command this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_WIDTH  target register address.
REQ-009 req_dat  input  8  write data (ignored for reads).
REQ-010 rsp_valid  output  1  completion response present.
REQ-011 rsp_ready  input  1  consumer accepts response.
REQ-012 rsp_dat  output  8  read data (0 for writes and errors).
REQ-013 rsp_err  output  1  transaction aborted by timeout.
REQ-014 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone cycle, strobe, write enable.
REQ-015 wb_adr_o  output  ADDR_WIDTH  Wishbone address.
REQ-016 wb_dat_o  output  8  Wishbone write data.
REQ-017 wb_dat_i  input  8  Wishbone read data.
REQ-018 wb_ack_i  input  1  Wishbone acknowledge.

Function
REQ-019 States SHALL be IDLE, BUS, RESP; one transaction outstanding at a time.
REQ-020 req_ready SHALL be 1 exactly when state is IDLE.
REQ-021 IDLE: on req_valid=1, capture req_we/req_addr/req_dat into output registers, go to BUS; wb_cyc_o=wb_stb_o=1 from the next cycle.
REQ-022 BUS: wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o held stable until the transaction ends.
REQ-023 BUS with wb_ack_i=1 sampled: next cycle wb_cyc_o=wb_stb_o=0; rsp_dat=wb_dat_i for reads, 0 for writes; rsp_err=0; rsp_valid=1; go to RESP.
REQ-024 BUS timeout counter SHALL clear on BUS entry and increment per BUS cycle without ack; reaching TIMEOUT with no ack: drop cyc/stb next cycle, rsp_err=1, rsp_dat=0, rsp_valid=1, go to RESP.
REQ-025 Ack and timeout in the same cycle: ack wins, rsp_err=0.
REQ-026 RESP: rsp_valid, rsp_dat, rsp_err held until rsp_ready=1; then rsp_valid=0 and go to IDLE next cycle.
REQ-027 wb_ack_i outside BUS (e.g. the trailing ack of a registered-ack slave) SHALL be ignored with no state change.
REQ-028 Minimum latency, req accept to rsp_valid, against a slave acking one cycle after stb = 3 cycles; back-to-back requests separated by at least one cycle with wb_stb_o=0.
REQ-029 wb_cyc_o and wb_stb_o SHALL always be equal.

Reset
REQ-030 wb_rst_i=1 at a rising edge: state=IDLE, counter=0, all outputs 0 except req_ready=1, next cycle, including mid-BUS or mid-RESP (transaction dropped, no response).
REQ-031 Reset dominates every other condition in the same cycle.

Structure
REQ-032 State encodings and ADDR_WIDTH/TIMEOUT defaults SHALL live in a shared package, uart_wbm_pkg.
REQ-033 The timeout counter SHALL be one sub-module, uart_wbm_timeout (inputs clear/enable, output expired).

Verification
REQ-034 Write: req_we=1, addr=3, dat=0x83, slave acks 1 cycle after stb -> one strobe cycle pair with we=1, adr=3, dat=0x83; rsp_valid 3 cycles after accept, rsp_err=0, rsp_dat=0.
REQ-035 Read: addr=5, slave returns 0x60 with ack -> rsp_dat=0x60, rsp_err=0; trailing ack next cycle causes no second response.
REQ-036 Timeout: TIMEOUT=15, slave never acks -> cyc/stb drop after 15 BUS cycles, rsp_err=1, rsp_dat=0.
REQ-037 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid/rsp_dat stable, req_ready=0 throughout; completes on rsp_ready=1.
REQ-038 Reset mid-BUS: wb_rst_i=1 with stb high -> next cycle cyc=stb=0, rsp_valid=0, req_ready=1; following read completes normally.
REQ-039 Ack on the TIMEOUT-th cycle -> rsp_err=0, data captured.
